run_sequencer: RTL and testbench
================================

# run_sequencer

Host-side initiator for the core's Start/Done handshake. It accepts a run request for a program slot, resets and parks the core, releases `Start`, and times the run until `Done` rises or a watchdog expires. It then returns the cycle count and status on a valid/ready response port. It sits between the testbench or host interface and the core top level, and drives the core's `Reset`, `Start` and program select.

## Interface
Parameters:
- `RST_CYCLES`, 2: cycles `Core_Reset` is held high per run (≥1)
- `START_CYCLES`, 2: cycles `Core_Start` is held high after core reset release (≥1)
- `CYC_W`, 16: width of the cycle counter and `Rsp_cycles`
- `TIMEOUT`, 50000: watchdog limit in RUN cycles; 1 ≤ TIMEOUT ≤ 2^CYC_W−1

Ports:
- `Clk` in 1: clock; all logic on the rising edge
- `Reset` in 1: synchronous, active-low; resets this block only
- `Req_valid` in 1: run request
- `Req_ready` out 1: high only in IDLE
- `Req_prog` in 2: program slot to run
- `Core_Reset` out 1: active-high reset to the core
- `Core_Start` out 1: core Start; high parks the core, low lets it run
- `Core_Prog` out 2: program select; stable from request acceptance through RESP
- `Core_Done` in 1: core completion flag (level)
- `Rsp_valid` out 1: result available
- `Rsp_ready` in 1: host accepts result
- `Rsp_cycles` out CYC_W: RUN cycles to completion
- `Rsp_timeout` out 1: watchdog expired
- `Busy` out 1: state ≠ IDLE

## Operation
- **States:** IDLE → RST → START → RUN → RESP → IDLE.
- **IDLE:**
  - `Req_ready`=1.
  - On `Req_valid`: latch `Req_prog` into `Core_Prog`, clear the counter, go to RST.
- **RST:**
  - `Core_Reset`=1 for exactly RST_CYCLES cycles, then go to START.
- **START:**
  - `Core_Start`=1 for exactly START_CYCLES cycles, then go to RUN.
  - `Done_q` samples `Core_Done` every cycle here, so a stale high `Done` is not taken as completion.
- **RUN:**
  - `Core_Start`=0.
  - The counter increments each cycle; it reads 1 on the first RUN cycle.
  - Completion = `Core_Done & ~Done_q`, a rising edge sampled in RUN. On completion, load `Rsp_cycles` = counter value in that cycle and `Rsp_timeout`=0.
  - If the counter reaches TIMEOUT with no edge: `Rsp_cycles`=TIMEOUT, `Rsp_timeout`=1.
  - If an edge and the limit occur in the same cycle, completion wins (`Rsp_timeout`=0).
  - Either outcome goes to RESP.
- **RESP:**
  - `Rsp_valid`=1; `Rsp_cycles` and `Rsp_timeout` are held stable until `Rsp_valid & Rsp_ready`, then go to IDLE.
- **Core_Start:** 1 in every state except RUN.
- **Core_Reset:** 1 only in RST and while `Reset`=0.
- **Done stuck high:** if `Core_Done` is already high and stays high through RUN, there is no rising edge, so the run ends in timeout. This is the required behaviour.
- **Reset mid-operation:** `Reset`=0 in any state → IDLE next edge.
  - Cleared: counters, `Rsp_valid`, `Rsp_cycles`, `Rsp_timeout`, `Core_Prog`, `Done_q`.
  - Any pending response is discarded.

## Timing
- All outputs are registered.
- Reset values: `Req_ready`=1, `Busy`=0, `Core_Reset`=1 while `Reset`=0 (0 on the first cycle after release), `Core_Start`=1, `Core_Prog`=0, `Rsp_valid`=0, `Rsp_cycles`=0, `Rsp_timeout`=0.
- Request accepted at edge T:
  - `Core_Reset` is high for cycles T+1 … T+RST_CYCLES.
  - `Core_Start` goes low at T+RST_CYCLES+START_CYCLES+1, the first RUN cycle.
- Completion edge sampled at the edge ending RUN cycle n → `Rsp_valid`=1 in the next cycle with `Rsp_cycles`=n.
- Timeout: `Rsp_valid` rises in the cycle after RUN cycle TIMEOUT.
- Response handshake takes one cycle; `Req_ready`=1 in the cycle after the `Rsp` handshake. No back-to-back runs without an IDLE cycle.
- `Req_valid` outside IDLE is ignored, and `Req_prog` is not sampled.

## Structure
- Shared package `run_seq_pkg`:
  - `typedef enum logic[2:0] {IDLE, RST, START, RUN, RESP} run_state_t`
  - Default constants `RUN_RST_CYCLES`, `RUN_START_CYCLES`, `RUN_TIMEOUT`
- Sub-module `run_timer`: CYC_W-bit counter with clear, enable, and `At_limit` compare against TIMEOUT. The phase counters for RST and START reuse it with their own limits.

## Test plan
Configuration for all scenarios: RST_CYCLES=2, START_CYCLES=2, CYC_W=8, TIMEOUT=20.
- **Normal run:** request prog 2 at T; `Core_Done` rises in RUN cycle 7 → `Core_Reset` high T+1..T+2, `Core_Start` low from T+5, `Core_Prog`=2 throughout, `Rsp_valid` with `Rsp_cycles`=7, `Rsp_timeout`=0.
- **Stale Done:** `Core_Done` held high from before the request and never drops → `Rsp_cycles`=20, `Rsp_timeout`=1.
- **Simultaneous events:** `Done` edge in RUN cycle 20 → `Rsp_cycles`=20, `Rsp_timeout`=0.
- **Response backpressure:** `Rsp_ready`=0 for 5 cycles → `Rsp_valid` and data stable; `Req_valid` ignored (`Req_ready`=0); accepted on the 6th cycle, then `Req_ready`=1 next cycle.
- **Reset mid-run:** `Reset`=0 in RUN cycle 4 → next cycle IDLE, `Core_Reset`=1 while low, `Core_Start`=1, `Rsp_valid`=0; a later request runs normally.
- **Back-to-back runs:** prog 1 then prog 3 with immediate `Rsp_ready` → counter restarts at 1 and a fresh RST/START sequence occurs for each run.

Source files
------------

// File: rtl/run_seq_pkg.sv
// run_seq_pkg: shared state encoding and default timing constants for the run sequencer
package run_seq_pkg;
   typedef enum logic [2:0] {IDLE, RST, START, RUN, RESP} run_state_t;
   localparam int RUN_RST_CYCLES   = 2;
   localparam int RUN_START_CYCLES = 2;
   localparam int RUN_TIMEOUT      = 50000;
endpackage

// File: rtl/run_timer.sv
// run_timer: phase/run cycle counter; clear and enable together load 1 so a phase's first cycle reads 1
module run_timer #(
   parameter int CYC_W = 16
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             clr,
   input  logic             en,
   input  logic [CYC_W-1:0] limit,
   output logic [CYC_W-1:0] cnt,
   output logic             At_limit
);
   always_ff @(posedge Clk)
      cnt <= !Reset ? '0 : (clr ? '0 : cnt) + CYC_W'(en);
   assign At_limit = cnt == limit;
endmodule

// File: rtl/run_sequencer.sv
// run_sequencer: host-side Start/Done initiator that resets, parks, releases and times one core run
module run_sequencer
   import run_seq_pkg::*;
#(
   parameter int RST_CYCLES   = RUN_RST_CYCLES,
   parameter int START_CYCLES = RUN_START_CYCLES,
   parameter int CYC_W        = 16,
   parameter int TIMEOUT      = RUN_TIMEOUT
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Req_valid,
   output logic             Req_ready,
   input  logic [1:0]       Req_prog,
   output logic             Core_Reset,
   output logic             Core_Start,
   output logic [1:0]       Core_Prog,
   input  logic             Core_Done,
   output logic             Rsp_valid,
   input  logic             Rsp_ready,
   output logic [CYC_W-1:0] Rsp_cycles,
   output logic             Rsp_timeout,
   output logic             Busy
);
   run_state_t state, nxt;
   logic done_q, done_edge, at_limit;
   logic [CYC_W-1:0] cnt, limit;
   assign done_edge = Core_Done & ~done_q;
   assign limit = state == RST   ? CYC_W'(RST_CYCLES)
                : state == START ? CYC_W'(START_CYCLES)
                :                  CYC_W'(TIMEOUT);
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (Req_valid) nxt = RST;
         RST:     if (at_limit) nxt = START;
         START:   if (at_limit) nxt = RUN;
         RUN:     if (done_edge || at_limit) nxt = RESP;
         RESP:    if (Rsp_ready) nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end
   // one counter serves all three timed phases; it restarts on every state change
   run_timer #(.CYC_W(CYC_W)) u_timer (
      .Clk      (Clk),
      .Reset    (Reset),
      .clr      (nxt != state),
      .en       (nxt == RST || nxt == START || nxt == RUN),
      .limit    (limit),
      .cnt      (cnt),
      .At_limit (at_limit)
   );
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state       <= IDLE;
         Req_ready   <= 1'b1;
         Busy        <= 1'b0;
         Core_Reset  <= 1'b1;
         Core_Start  <= 1'b1;
         Core_Prog   <= '0;
         Rsp_valid   <= 1'b0;
         Rsp_cycles  <= '0;
         Rsp_timeout <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state      <= nxt;
         Req_ready  <= nxt == IDLE;
         Busy       <= nxt != IDLE;
         Core_Reset <= nxt == RST;
         Core_Start <= nxt != RUN;
         Rsp_valid  <= nxt == RESP;
         done_q     <= Core_Done;
         if (state == IDLE && Req_valid) Core_Prog <= Req_prog;
         // on a limit hit cnt already equals TIMEOUT; a simultaneous edge counts as completion
         if (state == RUN && nxt == RESP) begin
            Rsp_cycles  <= cnt;
            Rsp_timeout <= ~done_edge;
         end
      end
   end
endmodule

// File: tb/tb_run_sequencer.sv
// tb_run_sequencer: directed checks of the run sequencer with RST=2, START=2, CYC_W=8, TIMEOUT=20
module tb_run_sequencer;
   logic clk = 0, rst_n = 0, req_valid = 0, req_ready, core_reset, core_start, core_done = 0;
   logic rsp_valid, rsp_ready = 0, rsp_timeout, busy;
   logic [1:0] req_prog = 0, core_prog;
   logic [7:0] rsp_cycles;
   int checks = 0, errors = 0, n;

   run_sequencer #(.RST_CYCLES(2), .START_CYCLES(2), .CYC_W(8), .TIMEOUT(20)) dut (
      .Clk(clk), .Reset(rst_n), .Req_valid(req_valid), .Req_ready(req_ready), .Req_prog(req_prog),
      .Core_Reset(core_reset), .Core_Start(core_start), .Core_Prog(core_prog), .Core_Done(core_done),
      .Rsp_valid(rsp_valid), .Rsp_ready(rsp_ready), .Rsp_cycles(rsp_cycles),
      .Rsp_timeout(rsp_timeout), .Busy(busy)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   // accept a request, walk the RST/START phases, return in RUN cycle 1
   task automatic request(input logic [1:0] p);
      req_valid = 1;
      req_prog = p;
      tick;
      req_valid = 0;
      req_prog = ~p;
      check("rst_c1", 32'(core_reset), 1);
      check("busy", 32'(busy), 1);
      check("req_ready_busy", 32'(req_ready), 0);
      check("prog_latch", 32'(core_prog), 32'(p));
      tick;
      check("rst_c2", 32'(core_reset), 1);
      tick;
      check("start_c1", 32'({core_reset, core_start}), 1);
      tick;
      check("start_c2", 32'({core_reset, core_start}), 1);
      tick;
      check("run_c1_start", 32'(core_start), 0);
      check("run_c1_prog", 32'(core_prog), 32'(p));
   endtask

   task automatic expect_rsp(input string tag, input int cyc, input logic to);
      check({tag, "_valid"}, 32'(rsp_valid), 1);
      check({tag, "_cycles"}, 32'(rsp_cycles), 32'(cyc));
      check({tag, "_timeout"}, 32'(rsp_timeout), 32'(to));
   endtask

   task automatic handshake;
      rsp_ready = 1;
      tick;
      rsp_ready = 0;
      check("idle_ready", 32'(req_ready), 1);
      check("idle_valid", 32'(rsp_valid), 0);
   endtask

   initial begin
      tick;
      tick;
      check("rst_req_ready", 32'(req_ready), 1);
      check("rst_busy", 32'(busy), 0);
      check("rst_core_reset", 32'(core_reset), 1);
      check("rst_core_start", 32'(core_start), 1);
      check("rst_prog", 32'(core_prog), 0);
      check("rst_rsp", 32'({rsp_valid, rsp_cycles, rsp_timeout}), 0);
      rst_n = 1;
      tick;
      check("rel_core_reset", 32'(core_reset), 0);
      check("rel_req_ready", 32'(req_ready), 1);

      // normal run: Done rises in RUN cycle 7
      request(2);
      repeat (6) tick;
      check("norm_run7_start", 32'(core_start), 0);
      core_done = 1;
      tick;
      expect_rsp("norm", 7, 0);
      check("norm_prog", 32'(core_prog), 2);
      handshake;
      core_done = 0;

      // Done already high and stuck: watchdog must fire
      core_done = 1;
      tick;
      request(0);
      n = 0;
      for (int i = 1; i <= 30; i++) begin
         tick;
         if (rsp_valid) begin
            n = i;
            break;
         end
      end
      check("stale_latency", 32'(n), 20);
      expect_rsp("stale", 20, 1);
      handshake;
      core_done = 0;

      // edge in the final RUN cycle wins over the limit, then 5 cycles of backpressure
      request(1);
      repeat (19) tick;
      core_done = 1;
      tick;
      expect_rsp("simul", 20, 0);
      req_valid = 1;
      req_prog = 3;
      for (int i = 0; i < 4; i++) begin
         tick;
         expect_rsp("bp", 20, 0);
         check("bp_req_ready", 32'(req_ready), 0);
         check("bp_prog", 32'(core_prog), 1);
      end
      rsp_ready = 1;
      tick;
      req_valid = 0;
      rsp_ready = 0;
      check("bp_idle_ready", 32'(req_ready), 1);
      check("bp_idle_valid", 32'(rsp_valid), 0);
      check("bp_idle_busy", 32'(busy), 0);
      core_done = 0;

      // reset asserted in RUN cycle 4
      request(2);
      repeat (3) tick;
      rst_n = 0;
      tick;
      check("mid_req_ready", 32'(req_ready), 1);
      check("mid_busy", 32'(busy), 0);
      check("mid_core_reset", 32'(core_reset), 1);
      check("mid_core_start", 32'(core_start), 1);
      check("mid_prog", 32'(core_prog), 0);
      check("mid_rsp", 32'({rsp_valid, rsp_cycles, rsp_timeout}), 0);
      tick;
      check("mid_hold_reset", 32'(core_reset), 1);
      rst_n = 1;
      tick;
      check("mid_rel_reset", 32'(core_reset), 0);

      // back-to-back runs with immediate acceptance
      request(1);
      repeat (2) tick;
      core_done = 1;
      tick;
      expect_rsp("b2b1", 3, 0);
      handshake;
      core_done = 0;
      request(3);
      repeat (4) tick;
      core_done = 1;
      tick;
      expect_rsp("b2b2", 5, 0);
      check("b2b2_prog", 32'(core_prog), 3);
      handshake;
      core_done = 0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
